sum_collector: RTL and testbench
================================

SUM_COLLECTOR -- requirements
Module: sum_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, >=2.
REQ-002 SHALL have parameter ACC_W, default 8, accumulator width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rstx, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port in_sum, input, 4, sum word from the upstream adder stage.
REQ-006 SHALL have port in_en, input, 1, in_sum valid this cycle; no backpressure upstream.
REQ-007 SHALL have port out_data, output, 4, head-of-FIFO sum.
REQ-008 SHALL have port out_valid, output, 1, FIFO non-empty.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts out_data.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-011 SHALL have port acc, output, ACC_W, saturating total of all accepted sums.
REQ-012 SHALL have port overflow, output, 1, sticky: an input was dropped.

Function
REQ-013 SHALL define pop = out_valid && out_ready, and push = in_en && (count < DEPTH || pop).
REQ-014 SHALL write in_sum at the write pointer on push; the entry is visible on out_data the next cycle.
REQ-015 SHALL advance the read pointer on pop; out_data shows the next entry the following cycle.
REQ-016 SHALL wrap each pointer from DEPTH-1 to 0.
REQ-017 SHALL update count +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-018 SHALL treat push and pop in the same cycle at full as legal: no drop and count unchanged.
REQ-019 SHALL ignore out_ready when empty; in_en when empty only pushes.
REQ-020 SHALL drop in_sum and set overflow when in_en && full && !pop; storage, pointers, count and acc stay unchanged.
REQ-021 SHALL hold overflow at 1 until reset.
REQ-022 SHALL drive out_valid = (count != 0), registered-state derived, with no combinational path from in_en.
REQ-023 SHALL drive out_data = 0 when out_valid = 0.
REQ-024 SHALL set acc to min(acc + in_sum, 2^ACC_W-1) on push, zero-extending in_sum, with a one-cycle update latency.
REQ-025 SHALL leave acc unchanged on a dropped input.
REQ-026 SHALL preserve FIFO order: outputs appear in push order, with no duplication or loss except REQ-020 drops.

Reset
REQ-027 SHALL, in the cycle after rstx is sampled 0, have count=0, out_valid=0, out_data=0, acc=0, overflow=0, and both pointers at 0.
REQ-028 SHALL give rstx priority over simultaneous push or pop; all in-flight entries are discarded.
REQ-029 SHALL NOT require storage array contents to be reset.

Structure
REQ-030 SHALL place SUM_W=4, DEFAULT_DEPTH=4 and DEFAULT_ACC_W=8 in shared package sum_collector_pkg.
REQ-031 SHALL implement pointers, count and storage in sub-module sum_collector_fifo; the accumulator and overflow logic stay in sum_collector.

Verification
REQ-032 SHALL cover single push: after reset, in_en=1 and in_sum=7 for one cycle -> next cycle out_valid=1, out_data=7, count=1, acc=7.
REQ-033 SHALL cover full and overflow: out_ready=0, push 1,2,3,4,5 -> count=4, overflow=1, acc=10; drain -> 1,2,3,4 in order.
REQ-034 SHALL cover full with simultaneous push/pop: FIFO full with 1,2,3,4, in_en=1 with in_sum=9 and out_ready=1 -> count stays 4, overflow=0, later drain 2,3,4,9.
REQ-035 SHALL cover saturation: push 14 twenty times with out_ready=1 -> acc=255 after the 19th push and remains 255.
REQ-036 SHALL cover reset mid-operation: 3 entries held, rstx=0 for one cycle alongside in_en=1 -> next cycle count=0, out_valid=0, acc=0, overflow=0.
REQ-037 SHALL cover wrap-around: 10 consecutive pushes with out_ready=1 -> each value appears one cycle later in order, count stays at 1, and no overflow.

Source files
------------

// File: rtl/sum_collector_pkg.sv
// Shared widths and defaults for the sum collector block.
package sum_collector_pkg;
  localparam int SUM_W         = 4;
  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_ACC_W = 8;
endpackage

// File: rtl/sum_collector_fifo.sv
// Circular buffer of sum words: pointers, occupancy and reset-free storage.
module sum_collector_fifo
  import sum_collector_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rstx,
  input  logic                       push,
  input  logic                       pop,
  input  logic [SUM_W-1:0]           wr_data,
  output logic [SUM_W-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [SUM_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!rstx) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
endmodule

// File: rtl/sum_collector.sv
// Buffers upstream sums in a FIFO while keeping a saturating running total
// and a sticky flag for inputs dropped on a full buffer.
module sum_collector
  import sum_collector_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic                   clk,
  input  logic                   rstx,
  input  logic [SUM_W-1:0]       in_sum,
  input  logic                   in_en,
  output logic [SUM_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic [ACC_W-1:0]       acc,
  output logic                   overflow
);
  logic             push;
  logic             pop;
  logic             full;
  logic [SUM_W-1:0] rd_data;
  logic [ACC_W:0]   acc_sum;

  sum_collector_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstx    (rstx),
    .push    (push),
    .pop     (pop),
    .wr_data (in_sum),
    .rd_data (rd_data),
    .count   (count),
    .full    (full)
  );

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? rd_data : '0;
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push      = in_en && (!full || pop);

  assign acc_sum   = {1'b0, acc} + (ACC_W + 1)'(in_sum);

  always_ff @(posedge clk) begin
    if (!rstx) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        acc <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      if (in_en && !push)
        overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sum_collector.sv
// Scenario bench for sum_collector with a queue-based scoreboard of pushed sums.
module tb_sum_collector;
  logic       clk;
  logic       rstx;
  logic [3:0] in_sum;
  logic       in_en;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic [7:0] acc;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_q[$];
  int m_count = 0;
  int m_acc   = 0;
  bit m_ovf   = 0;

  sum_collector #(.DEPTH(4), .ACC_W(8)) dut (
    .clk       (clk),
    .rstx      (rstx),
    .in_sum    (in_sum),
    .in_en     (in_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .acc       (acc),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus: pops and checks the head, pushes accepted sums,
  // then checks the registered state after the edge.
  task automatic cycle(input logic en, input logic [3:0] sum, input logic rdy);
    logic       mpop;
    logic       mpush;
    logic [3:0] exp;
    in_en     = en;
    in_sum    = sum;
    out_ready = rdy;
    mpop = (m_count != 0) && rdy;
    if (mpop) begin
      exp = exp_q.pop_front();
      total++;
      if (out_data !== exp) begin
        bad++;
        $display("FAIL pop_data: got %0d want %0d", out_data, exp);
      end
    end
    mpush = en && ((m_count < 4) || mpop);
    if (mpush) begin
      exp_q.push_back(sum);
      m_acc = (m_acc + int'(sum) > 255) ? 255 : m_acc + int'(sum);
    end else if (en) begin
      m_ovf = 1'b1;
    end
    if (mpush && !mpop) m_count++;
    else if (mpop && !mpush) m_count--;
    @(posedge clk); #1;
    total++;
    if (count !== 3'(m_count)) begin
      bad++;
      $display("FAIL model_count: got %0d want %0d", count, m_count);
    end
    total++;
    if (out_valid !== (m_count != 0)) begin
      bad++;
      $display("FAIL model_valid: got %0b want %0b", out_valid, m_count != 0);
    end
    total++;
    if (acc !== 8'(m_acc)) begin
      bad++;
      $display("FAIL model_acc: got %0d want %0d", acc, m_acc);
    end
    total++;
    if (overflow !== m_ovf) begin
      bad++;
      $display("FAIL model_overflow: got %0b want %0b", overflow, m_ovf);
    end
    if (m_count == 0) begin
      total++;
      if (out_data !== 4'd0) begin
        bad++;
        $display("FAIL empty_data: got %0d want 0", out_data);
      end
    end
  endtask

  task automatic do_reset(input logic en);
    rstx      = 1'b0;
    in_en     = en;
    in_sum    = 4'd5;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rstx  = 1'b1;
    in_en = 1'b0;
    exp_q.delete();
    m_count = 0;
    m_acc   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 4'd0 ||
        acc !== 8'd0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got cnt=%0d v=%0b d=%0d acc=%0d ovf=%0b want all 0",
               count, out_valid, out_data, acc, overflow);
    end
  endtask

  task automatic test_single_push;
    do_reset(1'b0);
    cycle(1'b1, 4'd7, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'd7 || count !== 3'd1 || acc !== 8'd7) begin
      bad++;
      $display("FAIL single_push: got v=%0b d=%0d cnt=%0d acc=%0d want v=1 d=7 cnt=1 acc=7",
               out_valid, out_data, count, acc);
    end
    cycle(1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_full_overflow;
    do_reset(1'b0);
    for (int v = 1; v <= 5; v++) cycle(1'b1, 4'(v), 1'b0);
    total++;
    if (count !== 3'd4 || overflow !== 1'b1 || acc !== 8'd10) begin
      bad++;
      $display("FAIL full_overflow: got cnt=%0d ovf=%0b acc=%0d want cnt=4 ovf=1 acc=10",
               count, overflow, acc);
    end
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (out_data !== 4'(i)) begin
        bad++;
        $display("FAIL drain_order: got %0d want %0d", out_data, i);
      end
      cycle(1'b0, 4'd0, 1'b1);
    end
  endtask

  task automatic test_reset_mid;
    // Overflow is still set from the previous scenario, so reset must clear it.
    for (int v = 1; v <= 3; v++) cycle(1'b1, 4'(v + 10), 1'b0);
    do_reset(1'b1);
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0 || acc !== 8'd0 ||
        overflow !== 1'b0 || out_data !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid: got cnt=%0d v=%0b acc=%0d ovf=%0b d=%0d want all 0",
               count, out_valid, acc, overflow, out_data);
    end
    cycle(1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_full_push_pop;
    logic [3:0] want [4];
    want[0] = 4'd2; want[1] = 4'd3; want[2] = 4'd4; want[3] = 4'd9;
    do_reset(1'b0);
    for (int v = 1; v <= 4; v++) cycle(1'b1, 4'(v), 1'b0);
    cycle(1'b1, 4'd9, 1'b1);
    total++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL full_push_pop: got cnt=%0d ovf=%0b want cnt=4 ovf=0", count, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_data !== want[i]) begin
        bad++;
        $display("FAIL push_pop_order: got %0d want %0d", out_data, want[i]);
      end
      cycle(1'b0, 4'd0, 1'b1);
    end
  endtask

  task automatic test_saturation;
    int e;
    do_reset(1'b0);
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, 4'd14, 1'b1);
      e = (14 * i > 255) ? 255 : 14 * i;
      total++;
      if (acc !== 8'(e)) begin
        bad++;
        $display("FAIL saturation: push %0d got acc=%0d want %0d", i, acc, e);
      end
    end
    cycle(1'b0, 4'd0, 1'b1);
  endtask

  task automatic test_back_to_back;
    do_reset(1'b0);
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 4'(i), 1'b1);
      total++;
      if (count !== 3'd1 || out_data !== 4'(i) || overflow !== 1'b0) begin
        bad++;
        $display("FAIL wrap: push %0d got cnt=%0d d=%0d ovf=%0b want cnt=1 d=%0d ovf=0",
                 i, count, out_data, overflow, i);
      end
    end
    cycle(1'b0, 4'd0, 1'b1);
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL wrap_drain: got cnt=%0d v=%0b want cnt=0 v=0", count, out_valid);
    end
  endtask

  initial begin
    rstx      = 1'b0;
    in_en     = 1'b0;
    in_sum    = 4'd0;
    out_ready = 1'b0;
    test_reset();
    test_single_push();
    test_full_overflow();
    test_reset_mid();
    test_full_push_pop();
    test_saturation();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
